axis_i2s_slave_rx: RTL and testbench

I2S receiver in slave mode: bit clock, word clock and serial data are all driven by an external master such as a codec or another board. The block synchronises them into the `aclk` domain and deserialises 24-bit left and right samples. Each complete stereo frame is presented as one AXI-Stream beat, in the same 64-bit layout the `axis_i2s_tx` slave port accepts, so RX-to-TX loopback is a direct wire.

---
 rtl/i2s_pkg.sv | 29 ++
 rtl/i2s_in_sync.sv | 46 ++++
 rtl/axis_i2s_slave_rx.sv | 159 +++++++++++++++
 tb/tb_axis_i2s_slave_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word/slot sizes, lrck polarity and the 64-bit stereo frame
// layout used on both the RX master and TX slave AXI-Stream ports.
package i2s_pkg;

    localparam int unsigned I2S_DATA_WIDTH = 24;
    localparam int unsigned I2S_SLOT_WIDTH = 32;
    localparam int unsigned I2S_CHAN_WIDTH = 24;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    typedef struct packed {
        logic [7:0]                right_pad;
        logic [I2S_CHAN_WIDTH-1:0] right;
        logic [7:0]                left_pad;
        logic [I2S_CHAN_WIDTH-1:0] left;
    } i2s_frame_t;

    function automatic i2s_frame_t make_frame(input logic [I2S_CHAN_WIDTH-1:0] l,
                                              input logic [I2S_CHAN_WIDTH-1:0] r);
        i2s_frame_t f;
        f.right_pad = 8'd0;
        f.right     = r;
        f.left_pad  = 8'd0;
        f.left      = l;
        return f;
    endfunction

endpackage

// File: rtl/i2s_in_sync.sv
// Synchronises external sclk/lrck/sdin into the aclk domain and emits a one-cycle bit_stb
// on each sclk rising edge, with lrck/sdin sampled alongside it.
module i2s_in_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic aclk,
    input  logic reset,
    input  logic sclk,
    input  logic lrck,
    input  logic sdin,
    output logic bit_stb,
    output logic lrck_smp,
    output logic sdin_smp
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic                   sclk_prev;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("i2s_in_sync: SYNC_STAGES must be at least 2");
    end

    // Strobe and data samples are registered together so they stay aligned.
    always_ff @(posedge aclk) begin
        if (reset) begin
            sclk_sync <= '0;
            lrck_sync <= '0;
            sdin_sync <= '0;
            sclk_prev <= 1'b0;
            bit_stb   <= 1'b0;
            lrck_smp  <= 1'b0;
            sdin_smp  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            bit_stb   <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            lrck_smp  <= lrck_sync[SYNC_STAGES-1];
            sdin_smp  <= sdin_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/axis_i2s_slave_rx.sv
// I2S slave receiver: deserialises left/right words and emits one AXI-Stream beat per frame.
// Optional build macro I2S_SLAVE_RX_OVF_CNT_EN adds a saturating dropped-frame counter port.
module axis_i2s_slave_rx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = I2S_DATA_WIDTH,
    parameter int unsigned SLOT_WIDTH  = I2S_SLOT_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        lrck,
    input  logic        sdin,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        overflow
`ifdef I2S_SLAVE_RX_OVF_CNT_EN
    ,
    output logic [15:0] ovf_count
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

    if (SLOT_WIDTH < DATA_WIDTH + 1) begin : g_bad_slot
        $error("axis_i2s_slave_rx: SLOT_WIDTH must be at least DATA_WIDTH+1");
    end
    if (DATA_WIDTH > I2S_CHAN_WIDTH || DATA_WIDTH < 2) begin : g_bad_width
        $error("axis_i2s_slave_rx: DATA_WIDTH must be in 2..24");
    end

    logic                  bit_stb;
    logic                  lrck_smp;
    logic                  sdin_smp;

    logic [CNT_W-1:0]      bit_cnt;
    logic                  chan;
    logic                  lrck_last;
    logic                  lrck_seen;
    logic                  armed;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] left_hold;
    logic [DATA_WIDTH-1:0] right_hold;
    logic                  have_left;
    logic                  frame_rdy;

    logic [DATA_WIDTH-1:0] word_next;
    logic                  lrck_edge;
    logic                  word_open;

    i2s_frame_t            frame_out;
    logic                  drop_frame;

    i2s_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .aclk    (aclk),
        .reset   (reset),
        .sclk    (sclk),
        .lrck    (lrck),
        .sdin    (sdin),
        .bit_stb (bit_stb),
        .lrck_smp(lrck_smp),
        .sdin_smp(sdin_smp)
    );

    always_comb begin
        word_next = {shift[DATA_WIDTH-2:0], sdin_smp};
        // The first strobe after reset only records lrck; it cannot be an edge.
        lrck_edge = lrck_seen && (lrck_smp != lrck_last);
        word_open = armed && (bit_cnt != FULL_CNT);
    end

    // Nothing is captured until the first lrck edge, so a reset mid-word never
    // yields a shifted partial word.
    always_ff @(posedge aclk) begin
        if (reset) begin
            bit_cnt    <= '0;
            chan       <= LRCK_LEFT;
            lrck_last  <= 1'b0;
            lrck_seen  <= 1'b0;
            armed      <= 1'b0;
            shift      <= '0;
            left_hold  <= '0;
            right_hold <= '0;
            have_left  <= 1'b0;
            frame_rdy  <= 1'b0;
        end else begin
            frame_rdy <= 1'b0;
            if (bit_stb) begin
                lrck_last <= lrck_smp;
                lrck_seen <= 1'b1;
                if (lrck_edge) begin
                    if (word_open && chan == LRCK_LEFT) begin
                        have_left <= 1'b0;
                    end
                    bit_cnt <= '0;
                    chan    <= lrck_smp;
                    armed   <= 1'b1;
                end else if (word_open) begin
                    shift   <= word_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (chan == LRCK_LEFT) begin
                            left_hold <= word_next;
                            have_left <= 1'b1;
                        end else if (have_left) begin
                            right_hold <= word_next;
                            have_left  <= 1'b0;
                            frame_rdy  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign drop_frame = frame_rdy && m_axis_tvalid && !m_axis_tready;

    always_ff @(posedge aclk) begin
        if (reset) begin
            frame_out     <= '0;
            m_axis_tvalid <= 1'b0;
            overflow      <= 1'b0;
        end else if (frame_rdy) begin
            if (!m_axis_tvalid || m_axis_tready) begin
                frame_out     <= make_frame(I2S_CHAN_WIDTH'(left_hold),
                                            I2S_CHAN_WIDTH'(right_hold));
                m_axis_tvalid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef I2S_SLAVE_RX_OVF_CNT_EN
    always_ff @(posedge aclk) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (drop_frame && ovf_count != 16'hFFFF) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_frame;
`endif

    assign m_axis_tdata = frame_out;
    assign m_axis_tlast = 1'b1;

endmodule

// File: tb/tb_axis_i2s_slave_rx.sv
// Directed bench for axis_i2s_slave_rx: drives an I2S master at aclk/8 with 32-bit slots.
// Honours I2S_SLAVE_RX_OVF_CNT_EN for the dropped-frame counter check.
module tb_axis_i2s_slave_rx;

    logic        aclk;
    logic        reset;
    logic        sclk;
    logic        lrck;
    logic        sdin;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        overflow;
`ifdef I2S_SLAVE_RX_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    int          n_tests;
    int          n_fail;
    int          valid_cycles;
    logic [63:0] beat_q[$];

    axis_i2s_slave_rx dut (
        .aclk         (aclk),
        .reset        (reset),
        .sclk         (sclk),
        .lrck         (lrck),
        .sdin         (sdin),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .overflow     (overflow)
`ifdef I2S_SLAVE_RX_OVF_CNT_EN
        ,
        .ovf_count    (ovf_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (m_axis_tvalid) begin
            valid_cycles++;
            if (m_axis_tready) beat_q.push_back(m_axis_tdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] expf(input logic [23:0] l, input logic [23:0] r);
        return {8'h00, r, 8'h00, l};
    endfunction

    // Data changes while sclk is low; the receiver samples on the rising edge.
    task automatic send_bit(input logic l, input logic d);
        sclk = 1'b0;
        lrck = l;
        sdin = d;
        #40;
        sclk = 1'b1;
        #40;
    endtask

    task automatic send_slot(input logic l, input logic [23:0] w, input int nbits,
                             input logic pad);
        logic d;
        for (int i = 0; i < nbits; i++) begin
            if (i >= 1 && i <= 24) d = w[24-i];
            else d = pad;
            send_bit(l, d);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic pad);
        send_slot(1'b0, l, 32, pad);
        send_slot(1'b1, r, 32, pad);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #40;
        reset = 1'b0;
    endtask

    initial begin
        int nb;
        n_tests       = 0;
        n_fail        = 0;
        valid_cycles  = 0;
        reset         = 1'b1;
        sclk          = 1'b0;
        lrck          = 1'b0;
        sdin          = 1'b0;
        m_axis_tready = 1'b1;
        #42;
        check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("tlast_const", {63'd0, m_axis_tlast}, 64'd1);
        reset = 1'b0;

        // 1: basic frames with tready held high
        send_slot(1'b1, 24'h000000, 32, 1'b0);
        check("t1_lead_no_beat", 64'(beat_q.size()), 64'd0);
        valid_cycles = 0;
        send_frame(24'h123456, 24'hABCDEF, 1'b0);
        check("t1_beats", 64'(beat_q.size()), 64'd1);
        check("t1_data", beat_q[$], 64'h00ABCDEF_00123456);
        check("t1_valid_cycles", 64'(valid_cycles), 64'd1);
        send_frame(24'h0F1E2D, 24'h3C4B5A, 1'b0);
        check("t1_beats2", 64'(beat_q.size()), 64'd2);
        check("t1_data2", beat_q[$], expf(24'h0F1E2D, 24'h3C4B5A));

        // 2: back-pressure for three frames
        m_axis_tready = 1'b0;
        nb = beat_q.size();
        send_frame(24'h111111, 24'h222222, 1'b0);
        check("t2_first_held", m_axis_tdata, expf(24'h111111, 24'h222222));
        check("t2_no_ovf_yet", {63'd0, overflow}, 64'd0);
        send_frame(24'h333333, 24'h444444, 1'b0);
        send_frame(24'h555555, 24'h666666, 1'b0);
        check("t2_tvalid_held", {63'd0, m_axis_tvalid}, 64'd1);
        check("t2_tdata_intact", m_axis_tdata, expf(24'h111111, 24'h222222));
        check("t2_overflow", {63'd0, overflow}, 64'd1);
`ifdef I2S_SLAVE_RX_OVF_CNT_EN
        check("t2_ovf_count", {48'd0, ovf_count}, 64'd2);
`endif
        m_axis_tready = 1'b1;
        #40;
        check("t2_drained", 64'(beat_q.size() - nb), 64'd1);
        check("t2_drained_data", beat_q[$], expf(24'h111111, 24'h222222));
        check("t2_tvalid_low", {63'd0, m_axis_tvalid}, 64'd0);
        check("t2_overflow_sticky", {63'd0, overflow}, 64'd1);

        // 3: reset part-way through a right word
        nb = beat_q.size();
        send_slot(1'b0, 24'h777777, 32, 1'b0);
        send_slot(1'b1, 24'h888888, 10, 1'b0);
        pulse_reset();
        check("t3_overflow_cleared", {63'd0, overflow}, 64'd0);
`ifdef I2S_SLAVE_RX_OVF_CNT_EN
        check("t3_ovf_count_cleared", {48'd0, ovf_count}, 64'd0);
`endif
        send_slot(1'b1, 24'h000000, 22, 1'b0);
        check("t3_no_beat", 64'(beat_q.size() - nb), 64'd0);
        send_frame(24'h13579B, 24'h2468AC, 1'b0);
        check("t3_beats", 64'(beat_q.size() - nb), 64'd1);
        check("t3_data", beat_q[$], expf(24'h13579B, 24'h2468AC));

        // 4: stimulus begins with a complete right slot after an lrck edge
        pulse_reset();
        nb = beat_q.size();
        send_slot(1'b0, 24'h000000, 4, 1'b0);
        send_slot(1'b1, 24'hDEADBE, 32, 1'b0);
        check("t4_right_discarded", 64'(beat_q.size() - nb), 64'd0);
        send_frame(24'hC0FFEE, 24'hBADA55, 1'b0);
        check("t4_beats", 64'(beat_q.size() - nb), 64'd1);
        check("t4_data", beat_q[$], expf(24'hC0FFEE, 24'hBADA55));

        // 5: truncated words; stale left must not pair with a later right
        nb = beat_q.size();
        send_slot(1'b0, 24'hF00F00, 32, 1'b0);
        send_slot(1'b1, 24'h0FF0FF, 11, 1'b0);
        send_slot(1'b0, 24'hA5A5A5, 11, 1'b0);
        send_slot(1'b1, 24'h5A5A5A, 32, 1'b0);
        check("t5_no_beat", 64'(beat_q.size() - nb), 64'd0);
        send_frame(24'h654321, 24'hFEDCBA, 1'b0);
        check("t5_beats", 64'(beat_q.size() - nb), 64'd1);
        check("t5_data", beat_q[$], expf(24'h654321, 24'hFEDCBA));

        // 6: bit-order patterns with ones on the delay and padding bits
        nb = beat_q.size();
        send_frame(24'h800000, 24'h7FFFFF, 1'b1);
        check("t6_msb_data", beat_q[$], 64'h007FFFFF_00800000);
        check("t6_pad_hi", {56'd0, beat_q[$][63:56]}, 64'd0);
        check("t6_pad_lo", {56'd0, beat_q[$][31:24]}, 64'd0);
        send_frame(24'hAAAAAA, 24'h555555, 1'b1);
        check("t6_alt_data", beat_q[$], 64'h00555555_00AAAAAA);
        check("t6_beats", 64'(beat_q.size() - nb), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
